wb_bus_arbiter: RTL

Two-master Wishbone arbiter with a bus-timeout watchdog, placed between the bus masters and the address-decoding interconnect. It grants the single downstream slave port (team designs, LA control, GPIO control) to one master at a time using round-robin, and holds the grant for the whole `cyc` cycle. It returns a synthetic error acknowledge when the addressed target never acknowledges, so neither master can hang the bus. Master 0 is the management SoC; master 1 is a secondary bus master such as a debug or test engine.

---
 rtl/wb_bus_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master round-robin Wishbone arbiter with bus-timeout watchdog
//
// Ports:
//   clk, nrst             clock, asynchronous active-low reset
//   m0_* / m1_*           Wishbone master ports (cyc, stb, we, sel, adr, dat in; ack, dat out)
//   s_*                   Wishbone port towards the address-decoding interconnect
//   grant                 one-hot owner (bit 0 = master 0), 2'b00 when idle
//   timeout_err           sticky flag, set on any watchdog timeout
//   timeout_clr           clears timeout_err (a simultaneous timeout wins)
module wb_bus_arbiter #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  grant,
   output logic        timeout_err,
   input  logic        timeout_clr
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t        state, state_nxt;
   logic          last, last_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          req0, req1, own, sel1, m_stb, to_ack, ack;
   logic [31:0]   dat;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;
   assign own  = state != IDLE;
   assign sel1 = state == GNT1;

   // Arbitration only happens in IDLE; an owner keeps the bus until its cyc falls
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (req0 & req1) begin
               state_nxt = last ? GNT0 : GNT1;
               last_nxt  = ~last;
            end else if (req0) begin
               state_nxt = GNT0;
               last_nxt  = 1'b0;
            end else if (req1) begin
               state_nxt = GNT1;
               last_nxt  = 1'b1;
            end
         end
         GNT0:    state_nxt = m0_cyc_i ? GNT0 : IDLE;
         GNT1:    state_nxt = m1_cyc_i ? GNT1 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Owner's request path; everything reads 0 while idle
   always_comb begin
      s_cyc_o = 1'b0;
      m_stb   = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = 4'h0;
      s_adr_o = 32'h0;
      s_dat_o = 32'h0;
      if (own) begin
         s_cyc_o = sel1 ? m1_cyc_i : m0_cyc_i;
         m_stb   = sel1 ? m1_stb_i : m0_stb_i;
         s_we_o  = sel1 ? m1_we_i  : m0_we_i;
         s_sel_o = sel1 ? m1_sel_i : m0_sel_i;
         s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
         s_dat_o = sel1 ? m1_dat_i : m0_dat_i;
      end
   end

   // A real acknowledge in the expiry cycle suppresses the synthetic one
   assign to_ack  = own & m_stb & ~s_ack_i & (cnt == CW'(TIMEOUT_CYCLES));
   assign s_stb_o = m_stb & ~to_ack;
   assign ack     = own & (s_ack_i | to_ack);
   assign dat     = to_ack ? TIMEOUT_DATA : s_dat_i;

   assign m0_ack_o = (state == GNT0) & ack;
   assign m1_ack_o = sel1 & ack;
   assign m0_dat_o = (state == GNT0) ? dat : 32'h0;
   assign m1_dat_o = sel1 ? dat : 32'h0;
   assign grant    = {sel1, state == GNT0};

   // Counts unacknowledged strobe cycles; the forced-low strobe on expiry clears it
   assign cnt_nxt = (own & s_stb_o & ~s_ack_i) ? cnt + CW'(1) : '0;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         last        <= 1'b1;
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         last        <= last_nxt;
         cnt         <= cnt_nxt;
         timeout_err <= to_ack ? 1'b1 : timeout_clr ? 1'b0 : timeout_err;
      end
   end

endmodule
